anomaly_detector_mc: RTL and testbench
======================================

Name: anomaly_detector_mc

Overview:
Multi-channel, parametrised successor to the single-stream anomaly detector. It takes a time-multiplexed stream of tagged price and volume samples for NCH instruments and keeps per-channel EMA baselines with warm-up gating. Each channel runs four detectors (spike, volume surge, volume dry, flash crash), with per-detector debounce, sticky per-channel alert flags with acknowledge, and a one-cycle event pulse for the alert/IRQ path.

Parameters:
DW, 12, price/volume/threshold width
NCH, 4, number of channels (>=2)
CHW, $clog2(NCH), channel index width
AVG_SHIFT, 3, EMA weight 2^-AVG_SHIFT
WARMUP, 8, samples per channel/type before avg-based detectors are enabled (>=1)
DEBOUNCE, 1, consecutive hits required to set an alert (>=1)
DRY_MIN, 10, vol_avg must exceed this for dry detection

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  sample strobe
in_ch  in  CHW  sample channel
in_type  in  2  00 price, 01 volume, 10/11 ignored
in_data  in  DW  sample value
spike_thresh  in  DW  price step threshold
flash_thresh  in  DW  drop-below-average threshold
ack_valid  in  1  acknowledge strobe
ack_ch  in  CHW  channel to acknowledge
ack_mask  in  4  sticky bits to clear
rd_ch  in  CHW  status readback select
alert_sticky  out  4*NCH  sticky flags; channel c occupies bits [4c+3:4c]
alert_any  out  1  OR of alert_sticky
event_valid  out  1  one-cycle pulse: new alert set
event_ch  out  CHW  channel of event
event_type  out  2  0 spike, 1 surge, 2 dry, 3 flash
rd_price_avg  out  DW  price_avg[rd_ch], combinational
rd_vol_avg  out  DW  vol_avg[rd_ch], combinational

Behaviour:
- Reset: all outputs 0. Per-channel cur_price, price_avg, vol_avg, warm counters, debounce counters and sticky flags are 0.
- Acceptance: a sample is accepted when in_valid=1, in_ch<NCH and in_type is 00 or 01. Any other sample is ignored with no state change. No backpressure: one sample per cycle.
- Detection uses the incoming sample against the stored state of the addressed channel, before that state is updated:
  - spike: pwarm>=1 and |in_data - cur_price| > spike_thresh.
  - flash: pwarm==WARMUP and price_avg > in_data and (price_avg - in_data) > flash_thresh.
  - surge: vwarm==WARMUP and vol_avg != 0 and in_data > 2*vol_avg, compared at DW+1 bits.
  - dry: vwarm==WARMUP and vol_avg > DRY_MIN and in_data < (vol_avg>>2).
- State update on an accepted price sample:
  - cur_price <= in_data.
  - price_avg <= in_data if pwarm==0; otherwise avg + ((in_data - avg) >>> AVG_SHIFT), using signed DW+1 arithmetic with an arithmetic (flooring) shift.
  - pwarm increments and saturates at WARMUP.
- State update on an accepted volume sample: the same EMA and warm rule applied to vol_avg and vwarm.
- Debounce: each channel/detector pair has its own counter. Only samples of the relevant type update it:
  - hit: counter increments, saturating at DEBOUNCE;
  - miss: counter clears to 0.
  - The detector "fires" when the counter after the update equals DEBOUNCE.
- Sticky flags: a firing detector sets its sticky bit. Acknowledge clears alert_sticky[4*ack_ch +: 4] & ack_mask. If a set and a clear hit the same bit in the same cycle, set wins. Acknowledge does not touch debounce counters. ack_ch >= NCH is ignored.
- Event pulse: event_valid=1 in the cycle after a sample that newly sets at least one bit that was 0. event_ch is that sample's channel. event_type is the highest priority among the newly set bits, in the order flash > surge > dry > spike. A detector that fires while its bit is already set does not produce an event.
- Latency: outputs are registered, one cycle from sample to alert_sticky/event. alert_any follows alert_sticky in the same cycle.
- Parameter changes: threshold inputs are sampled every cycle and may change at any time.
- Mid-operation reset clears everything immediately, including the pending event.

Decomposition:
- Package anomaly_pkg holds:
  - detector index constants (SPIKE=0, SURGE=1, DRY=2, FLASH=3);
  - the input-type constants;
  - the priority order function.
- Sub-module anomaly_ema: one parametrised EMA + warm counter, instantiated 2*NCH times.

Test Plan:
- Reset -> alert_sticky=0, alert_any=0, event_valid=0, rd_price_avg=0.
- ch0: price 100 x8, then 60 (spike_thresh=20, flash_thresh=30) -> next cycle event_valid=1, ch=0, type=3; alert_sticky[3:0]=4'b1001.
- ch1: volume 100 x8, then 250 -> type=1, alert_sticky[5]=1. Then ack_ch=1, mask=4'b0010 -> bit clears. Then volume 20 -> type=2.
- DEBOUNCE=2 build: prices 100, 150, 100 on ch2 -> event only after the third sample. With prices 100, 150, 150 -> no event.
- Ack on the same cycle as a new flash on ch0 -> bit stays 1. A lone ack then clears it, and alert_any falls to 0 on the same cycle.
- NCH=3 build: in_ch=3 ignored. Also, a ch0 100->40 drop after only 4 samples -> spike only (type 0), no flash; ch1 state unchanged.

Source files
------------

// File: rtl/anomaly_pkg.sv
// Shared constants and helpers for the multi-channel anomaly detector.
package anomaly_pkg;

  localparam int SPIKE = 0;
  localparam int SURGE = 1;
  localparam int DRY   = 2;
  localparam int FLASH = 3;

  localparam logic [1:0] TYPE_PRICE  = 2'b00;
  localparam logic [1:0] TYPE_VOLUME = 2'b01;

  // Event type reported for a set of newly raised bits: flash > surge > dry > spike.
  function automatic logic [1:0] top_priority(input logic [3:0] bits);
    if (bits[FLASH])      return 2'd3;
    else if (bits[SURGE]) return 2'd1;
    else if (bits[DRY])   return 2'd2;
    else                  return 2'd0;
  endfunction

endpackage

// File: rtl/anomaly_ema.sv
// One exponential moving average with a saturating warm-up counter.
module anomaly_ema #(
  parameter int DW        = 12,
  parameter int AVG_SHIFT = 3,
  parameter int WARMUP    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upd,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] avg,
  output logic          warm_any,
  output logic          warm_full
);

  localparam int WW = $clog2(WARMUP + 1);

  logic [WW-1:0]        warm;
  logic signed [DW:0]   diff;
  logic signed [DW:0]   step;
  logic [DW-1:0]        avg_next;

  // The stepped average always lies between avg and din, so DW bits suffice.
  always_comb begin
    diff     = $signed({1'b0, din}) - $signed({1'b0, avg});
    step     = diff >>> AVG_SHIFT;
    avg_next = avg + DW'(step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg  <= '0;
      warm <= '0;
    end else if (upd) begin
      avg <= (warm == '0) ? din : avg_next;
      if (warm != WW'(WARMUP)) warm <= warm + 1'b1;
    end
  end

  assign warm_any  = (warm != '0);
  assign warm_full = (warm == WW'(WARMUP));

endmodule

// File: rtl/anomaly_detector_mc.sv
// Multi-channel price/volume anomaly detector: per-channel EMA baselines,
// four debounced detectors, sticky flags with acknowledge and an event pulse.
module anomaly_detector_mc
  import anomaly_pkg::*;
#(
  parameter int DW        = 12,
  parameter int NCH       = 4,
  parameter int CHW       = $clog2(NCH),
  parameter int AVG_SHIFT = 3,
  parameter int WARMUP    = 8,
  parameter int DEBOUNCE  = 1,
  parameter int DRY_MIN   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CHW-1:0]   in_ch,
  input  logic [1:0]       in_type,
  input  logic [DW-1:0]    in_data,
  input  logic [DW-1:0]    spike_thresh,
  input  logic [DW-1:0]    flash_thresh,
  input  logic             ack_valid,
  input  logic [CHW-1:0]   ack_ch,
  input  logic [3:0]       ack_mask,
  input  logic [CHW-1:0]   rd_ch,
  output logic [4*NCH-1:0] alert_sticky,
  output logic             alert_any,
  output logic             event_valid,
  output logic [CHW-1:0]   event_ch,
  output logic [1:0]       event_type,
  output logic [DW-1:0]    rd_price_avg,
  output logic [DW-1:0]    rd_vol_avg
);

  localparam int DBW = $clog2(DEBOUNCE + 1);

  logic [DW-1:0]    cur_price [NCH];
  logic [DW-1:0]    price_avg [NCH];
  logic [DW-1:0]    vol_avg   [NCH];
  logic [NCH-1:0]   pwarm_any, pwarm_full, vwarm_any, vwarm_full;
  logic [DBW-1:0]   dbc [NCH][4];

  logic             ch_ok, accept, is_price, is_vol;
  logic [DW-1:0]    sel_cp, sel_pavg, sel_vavg, price_diff;
  logic             sel_pwarm_any, sel_pwarm_full, sel_vwarm_full;
  logic [DBW-1:0]   sel_dbc [4];
  logic [3:0]       sel_sticky, hit, relevant, fire, new_bits;
  logic [4*NCH-1:0] set_vec, clr_vec, sticky_next;

  assign ch_ok    = ({1'b0, in_ch} < (CHW+1)'(NCH));
  assign accept   = in_valid && ch_ok && !in_type[1];
  assign is_price = accept && (in_type == TYPE_PRICE);
  assign is_vol   = accept && (in_type == TYPE_VOLUME);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    anomaly_ema #(.DW(DW), .AVG_SHIFT(AVG_SHIFT), .WARMUP(WARMUP)) u_price_ema (
      .clk       (clk),
      .rst_n     (rst_n),
      .upd       (is_price && (in_ch == CHW'(c))),
      .din       (in_data),
      .avg       (price_avg[c]),
      .warm_any  (pwarm_any[c]),
      .warm_full (pwarm_full[c])
    );
    anomaly_ema #(.DW(DW), .AVG_SHIFT(AVG_SHIFT), .WARMUP(WARMUP)) u_vol_ema (
      .clk       (clk),
      .rst_n     (rst_n),
      .upd       (is_vol && (in_ch == CHW'(c))),
      .din       (in_data),
      .avg       (vol_avg[c]),
      .warm_any  (vwarm_any[c]),
      .warm_full (vwarm_full[c])
    );
  end

  always_comb begin
    sel_cp         = '0;
    sel_pavg       = '0;
    sel_vavg       = '0;
    sel_pwarm_any  = 1'b0;
    sel_pwarm_full = 1'b0;
    sel_vwarm_full = 1'b0;
    sel_sticky     = '0;
    for (int d = 0; d < 4; d++) sel_dbc[d] = '0;
    for (int c = 0; c < NCH; c++) begin
      if (in_ch == CHW'(c)) begin
        sel_cp         = cur_price[c];
        sel_pavg       = price_avg[c];
        sel_vavg       = vol_avg[c];
        sel_pwarm_any  = pwarm_any[c];
        sel_pwarm_full = pwarm_full[c];
        sel_vwarm_full = vwarm_full[c];
        sel_sticky     = alert_sticky[4*c +: 4];
        for (int d = 0; d < 4; d++) sel_dbc[d] = dbc[c][d];
      end
    end
  end

  always_comb begin
    price_diff      = (in_data >= sel_cp) ? (in_data - sel_cp) : (sel_cp - in_data);
    hit             = '0;
    hit[SPIKE]      = sel_pwarm_any && (price_diff > spike_thresh);
    hit[FLASH]      = sel_pwarm_full && (sel_pavg > in_data) &&
                      ((sel_pavg - in_data) > flash_thresh);
    hit[SURGE]      = sel_vwarm_full && (sel_vavg != '0) &&
                      ({1'b0, in_data} > {sel_vavg, 1'b0});
    hit[DRY]        = sel_vwarm_full && (sel_vavg > DW'(DRY_MIN)) &&
                      (in_data < (sel_vavg >> 2));
    relevant        = '0;
    relevant[SPIKE] = is_price;
    relevant[FLASH] = is_price;
    relevant[SURGE] = is_vol;
    relevant[DRY]   = is_vol;
    // A hit fires when it brings the counter up to (or keeps it at) DEBOUNCE.
    for (int d = 0; d < 4; d++)
      fire[d] = relevant[d] && hit[d] && (sel_dbc[d] >= DBW'(DEBOUNCE - 1));
    new_bits = fire & ~sel_sticky;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int c = 0; c < NCH; c++) begin
      if (accept && (in_ch == CHW'(c)))     set_vec[4*c +: 4] = fire;
      if (ack_valid && (ack_ch == CHW'(c))) clr_vec[4*c +: 4] = ack_mask;
    end
    sticky_next = (alert_sticky & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        cur_price[c] <= '0;
        for (int d = 0; d < 4; d++) dbc[c][d] <= '0;
      end
      alert_sticky <= '0;
      event_valid  <= 1'b0;
      event_ch     <= '0;
      event_type   <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (accept && (in_ch == CHW'(c))) begin
          if (is_price) cur_price[c] <= in_data;
          for (int d = 0; d < 4; d++) begin
            if (relevant[d]) begin
              if (!hit[d])                              dbc[c][d] <= '0;
              else if (dbc[c][d] != DBW'(DEBOUNCE))     dbc[c][d] <= dbc[c][d] + 1'b1;
            end
          end
        end
      end
      alert_sticky <= sticky_next;
      event_valid  <= |new_bits;
      if (|new_bits) begin
        event_ch   <= in_ch;
        event_type <= top_priority(new_bits);
      end
    end
  end

  assign alert_any = |alert_sticky;

  always_comb begin
    rd_price_avg = '0;
    rd_vol_avg   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == CHW'(c)) begin
        rd_price_avg = price_avg[c];
        rd_vol_avg   = vol_avg[c];
      end
    end
  end

endmodule

// File: tb/tb_anomaly_detector_mc.sv
// Self-checking bench: default build against a behavioural model, plus
// DEBOUNCE=2 and NCH=3 builds checked with hand-computed expectations.
module tb_anomaly_detector_mc;

  localparam int DW = 12, NCH = 4, CHW = 2, WARMUP = 8, DEB = 1, DRY_MIN = 10;

  logic clk, rst_n;
  int   checks = 0, failures = 0;

  // default instance
  logic             in_valid, ack_valid;
  logic [CHW-1:0]   in_ch, ack_ch, rd_ch;
  logic [1:0]       in_type;
  logic [DW-1:0]    in_data, spike_thresh, flash_thresh;
  logic [3:0]       ack_mask;
  logic [4*NCH-1:0] alert_sticky;
  logic             alert_any, event_valid;
  logic [CHW-1:0]   event_ch;
  logic [1:0]       event_type;
  logic [DW-1:0]    rd_price_avg, rd_vol_avg;

  // shared stimulus for the two alternate builds
  logic           x_valid, x_ack_valid;
  logic [1:0]     x_ch, x_ack_ch, x_rd_ch, x_type;
  logic [DW-1:0]  x_data;
  logic [3:0]     x_ack_mask;
  logic [15:0]    b_sticky;
  logic [11:0]    c_sticky;
  logic           b_any, b_ev, c_any, c_ev;
  logic [1:0]     b_ev_ch, b_ev_ty, c_ev_ch, c_ev_ty;
  logic [DW-1:0]  b_rpa, b_rva, c_rpa, c_rva;

  anomaly_detector_mc #(.DW(DW), .NCH(NCH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_type(in_type),
    .in_data(in_data), .spike_thresh(spike_thresh), .flash_thresh(flash_thresh),
    .ack_valid(ack_valid), .ack_ch(ack_ch), .ack_mask(ack_mask), .rd_ch(rd_ch),
    .alert_sticky(alert_sticky), .alert_any(alert_any), .event_valid(event_valid),
    .event_ch(event_ch), .event_type(event_type),
    .rd_price_avg(rd_price_avg), .rd_vol_avg(rd_vol_avg));

  anomaly_detector_mc #(.DW(DW), .NCH(4), .DEBOUNCE(2)) u_deb2 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ch(x_ch), .in_type(x_type),
    .in_data(x_data), .spike_thresh(spike_thresh), .flash_thresh(flash_thresh),
    .ack_valid(x_ack_valid), .ack_ch(x_ack_ch), .ack_mask(x_ack_mask), .rd_ch(x_rd_ch),
    .alert_sticky(b_sticky), .alert_any(b_any), .event_valid(b_ev),
    .event_ch(b_ev_ch), .event_type(b_ev_ty), .rd_price_avg(b_rpa), .rd_vol_avg(b_rva));

  anomaly_detector_mc #(.DW(DW), .NCH(3)) u_nch3 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ch(x_ch), .in_type(x_type),
    .in_data(x_data), .spike_thresh(spike_thresh), .flash_thresh(flash_thresh),
    .ack_valid(x_ack_valid), .ack_ch(x_ack_ch), .ack_mask(x_ack_mask), .rd_ch(x_rd_ch),
    .alert_sticky(c_sticky), .alert_any(c_any), .event_valid(c_ev),
    .event_ch(c_ev_ch), .event_type(c_ev_ty), .rd_price_avg(c_rpa), .rd_vol_avg(c_rva));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model of the default instance ----------------
  int         m_cp [NCH], m_pavg [NCH], m_vavg [NCH], m_pw [NCH], m_vw [NCH];
  int         m_db [NCH][4];
  logic [3:0] m_st [NCH];
  bit         e_ev;
  int         e_ch, e_ty;
  int         mc, md;
  bit         h_sp, h_fl, h_su, h_dr;
  logic [3:0] m_fire, m_nb;

  function automatic int ema(input int avg, input int w, input int d);
    if (w == 0) return d;
    return avg + ((d - avg) >>> 3);
  endfunction

  function automatic bit deb_step(inout int cnt, input bit h);
    cnt = h ? ((cnt < DEB) ? cnt + 1 : cnt) : 0;
    return h && (cnt == DEB);
  endfunction

  function automatic logic [4*NCH-1:0] exp_sticky();
    logic [4*NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[4*c +: 4] = m_st[c];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_cp[c] = 0; m_pavg[c] = 0; m_vavg[c] = 0; m_pw[c] = 0; m_vw[c] = 0; m_st[c] = 4'b0;
        for (int k = 0; k < 4; k++) m_db[c][k] = 0;
      end
      e_ev = 0; e_ch = 0; e_ty = 0;
    end else begin
      e_ev = 0;
      m_fire = 4'b0;
      m_nb = 4'b0;
      mc = int'(in_ch);
      md = int'(in_data);
      if (in_valid && in_type < 2) begin
        if (in_type == 2'b00) begin
          h_sp = m_pw[mc] >= 1 &&
                 ((md > m_cp[mc]) ? md - m_cp[mc] : m_cp[mc] - md) > int'(spike_thresh);
          h_fl = m_pw[mc] == WARMUP && m_pavg[mc] > md && m_pavg[mc] - md > int'(flash_thresh);
          m_fire[0] = deb_step(m_db[mc][0], h_sp);
          m_fire[3] = deb_step(m_db[mc][3], h_fl);
          m_cp[mc]   = md;
          m_pavg[mc] = ema(m_pavg[mc], m_pw[mc], md);
          if (m_pw[mc] < WARMUP) m_pw[mc]++;
        end else begin
          h_su = m_vw[mc] == WARMUP && m_vavg[mc] != 0 && md > 2 * m_vavg[mc];
          h_dr = m_vw[mc] == WARMUP && m_vavg[mc] > DRY_MIN && md < m_vavg[mc] / 4;
          m_fire[1] = deb_step(m_db[mc][1], h_su);
          m_fire[2] = deb_step(m_db[mc][2], h_dr);
          m_vavg[mc] = ema(m_vavg[mc], m_vw[mc], md);
          if (m_vw[mc] < WARMUP) m_vw[mc]++;
        end
        m_nb = m_fire & ~m_st[mc];
      end
      if (ack_valid) m_st[ack_ch] = m_st[ack_ch] & ~ack_mask;
      if (in_valid && in_type < 2) m_st[mc] = m_st[mc] | m_fire;
      if (m_nb != 0) begin
        e_ev = 1;
        e_ch = mc;
        e_ty = m_nb[3] ? 3 : m_nb[1] ? 1 : m_nb[2] ? 2 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_sticky", int'(alert_sticky), int'(exp_sticky()));
      chk("model_any", int'(alert_any), int'(exp_sticky() != 0));
      chk("model_event_valid", int'(event_valid), int'(e_ev));
      if (e_ev) begin
        chk("model_event_ch", int'(event_ch), e_ch);
        chk("model_event_type", int'(event_type), e_ty);
      end
      chk("model_rd_price_avg", int'(rd_price_avg), m_pavg[rd_ch]);
      chk("model_rd_vol_avg", int'(rd_vol_avg), m_vavg[rd_ch]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input int ch, input int ty, input int d,
                      input bit av, input int ach, input logic [3:0] am);
    in_valid = v; in_ch = 2'(ch); in_type = 2'(ty); in_data = DW'(d);
    ack_valid = av; ack_ch = 2'(ach); ack_mask = am;
    @(posedge clk); #1;
    in_valid = 1'b0; ack_valid = 1'b0;
  endtask

  task automatic xprice(input int ch, input int d);
    x_valid = 1'b1; x_ch = 2'(ch); x_type = 2'b00; x_data = DW'(d);
    @(posedge clk); #1;
    x_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_ch = 0; in_type = 0; in_data = 0;
    ack_valid = 0; ack_ch = 0; ack_mask = 0; rd_ch = 0;
    spike_thresh = 12'd20; flash_thresh = 12'd30;
    x_valid = 0; x_ch = 0; x_type = 0; x_data = 0;
    x_ack_valid = 0; x_ack_ch = 0; x_ack_mask = 0; x_rd_ch = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sticky", int'(alert_sticky), 0);
    chk("reset_any", int'(alert_any), 0);
    chk("reset_event", int'(event_valid), 0);
    chk("reset_rd_price_avg", int'(rd_price_avg), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ch0 flash + spike after warm-up
    for (int i = 0; i < 8; i++) step(1, 0, 0, 100, 0, 0, 4'b0);
    step(1, 0, 0, 60, 0, 0, 4'b0);
    chk("flash_event", int'(event_valid), 1);
    chk("flash_ch", int'(event_ch), 0);
    chk("flash_type", int'(event_type), 3);
    chk("flash_sticky", int'(alert_sticky[3:0]), 9);
    chk("flash_avg", int'(rd_price_avg), 95);

    // ch1 surge, ack, then dry
    rd_ch = 2'd1;
    for (int i = 0; i < 8; i++) step(1, 1, 1, 100, 0, 0, 4'b0);
    step(1, 1, 1, 250, 0, 0, 4'b0);
    chk("surge_type", int'(event_type), 1);
    chk("surge_bit", int'(alert_sticky[5]), 1);
    chk("surge_vol_avg", int'(rd_vol_avg), 118);
    step(0, 0, 0, 0, 1, 1, 4'b0010);
    chk("ack_clear_bit", int'(alert_sticky[5]), 0);
    step(1, 1, 1, 20, 0, 0, 4'b0);
    chk("dry_event", int'(event_valid), 1);
    chk("dry_type", int'(event_type), 2);
    chk("dry_ch", int'(event_ch), 1);

    step(1, 2, 2, 999, 0, 0, 4'b0);
    chk("ignored_type", int'(event_valid), 0);
    step(0, 0, 0, 0, 1, 1, 4'b1111);

    // set wins over a simultaneous ack; then a lone ack clears everything
    step(1, 0, 0, 60, 1, 0, 4'b1000);
    chk("set_wins", int'(alert_sticky[3]), 1);
    chk("set_wins_no_event", int'(event_valid), 0);
    step(0, 0, 0, 0, 1, 0, 4'b1111);
    chk("lone_ack_sticky", int'(alert_sticky), 0);
    chk("lone_ack_any", int'(alert_any), 0);

    // DEBOUNCE=2 and NCH=3 builds
    xprice(2, 100);
    xprice(2, 150);
    chk("deb2_no_early", int'(b_ev), 0);
    chk("nch3_spike_ev", int'(c_ev), 1);
    chk("nch3_spike_ch", int'(c_ev_ch), 2);
    xprice(2, 100);
    chk("deb2_event", int'(b_ev), 1);
    chk("deb2_ch", int'(b_ev_ch), 2);
    chk("deb2_type", int'(b_ev_ty), 0);
    chk("deb2_bit", int'(b_sticky[8]), 1);
    chk("nch3_already_set", int'(c_ev), 0);
    xprice(1, 100);
    xprice(1, 150);
    chk("deb2_ch1_first", int'(b_ev), 0);
    xprice(1, 150);
    chk("deb2_ch1_miss", int'(b_ev), 0);
    chk("deb2_ch1_sticky", int'(b_sticky[7:4]), 0);
    xprice(3, 500);
    chk("nch3_ch3_no_event", int'(c_ev), 0);
    chk("nch3_ch3_sticky", int'(c_sticky), 'h110);
    for (int i = 0; i < 4; i++) xprice(0, 100);
    xprice(0, 40);
    chk("nch3_drop_event", int'(c_ev), 1);
    chk("nch3_drop_type", int'(c_ev_ty), 0);
    chk("nch3_drop_ch", int'(c_ev_ch), 0);
    chk("nch3_drop_sticky", int'(c_sticky[3:0]), 1);
    chk("nch3_ch1_avg", int'(c_rpa), 111);

    // threshold change, then a pending event killed by reset
    spike_thresh = 12'd5;
    step(1, 0, 0, 50, 0, 0, 4'b0);
    rd_ch = 2'd3;
    step(1, 3, 0, 100, 0, 0, 4'b0);
    step(1, 3, 0, 200, 0, 0, 4'b0);
    chk("ch3_spike_event", int'(event_valid), 1);
    chk("ch3_spike_ch", int'(event_ch), 3);
    rst_n = 1'b0;
    #1;
    chk("midreset_event", int'(event_valid), 0);
    chk("midreset_sticky", int'(alert_sticky), 0);
    chk("midreset_avg", int'(rd_price_avg), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
